// File: rtl/sop_shared_cfg_eval_if.sv
// sop_shared_cfg_eval_if: handshake bundle for the shared-SOP evaluator.
//   Config side : cfg_start, cfg_valid, cfg_bit  -> evaluator
//                 cfg_ready, cfg_busy, cfg_done  <- evaluator
//   Operand side: in_valid, in_data              -> evaluator, in_ready <- evaluator
//   Result side : out_valid, out_data            <- evaluator, out_ready -> evaluator
// master = stimulus/host side, slave = evaluator side.
interface sop_shared_cfg_eval_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
);
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_busy;
  logic             cfg_done;
  logic             in_valid;
  logic [N_IN-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [N_OUT-1:0] out_data;
  logic             out_ready;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_busy, cfg_done, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    output cfg_ready, cfg_busy, cfg_done, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sop_shared_cfg_eval.sv
// sop_shared_cfg_eval: programmable shared-logic sum-of-products evaluator.
//
// N_PROD shared product terms over N_IN inputs are ORed into N_OUT outputs through an
// activation matrix. A serial config frame is loaded into a shadow bank while evaluation
// keeps running from the active bank; a one-cycle commit copies shadow to active.
//
// Frame layout (bit 0 sent first), per product p = 0..N_PROD-1:
//   for input i = 0..N_IN-1: pos bit, then neg bit   ({pos,neg}: 00 absent, 10 x, 01 ~x,
//                                                     11 product forced to 0)
//   then N_OUT activation bits, output 0 first.
// With SOP_EVAL_OUT_MASK_EN defined, N_OUT output-mask bits follow the last product
// (output 0 first) and out_data[j] = sop_j & mask[j]. Undefined: all outputs enabled.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    sop_shared_cfg_eval_if.slave (config stream, operand and result handshakes)
module sop_shared_cfg_eval #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned N_PROD = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  sop_shared_cfg_eval_if.slave bus
);

  localparam int unsigned ProdBits = 2 * N_IN + N_OUT;
`ifdef SOP_EVAL_OUT_MASK_EN
  localparam int unsigned CFG_BITS = N_PROD * ProdBits + N_OUT;
`else
  localparam int unsigned CFG_BITS = N_PROD * ProdBits;
`endif
  localparam int unsigned CntW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;

  logic                cfg_ready;
  logic                cfg_busy;
  logic                cfg_done;
  logic                cfg_acc;
  logic                last_bit;

  logic                in_ready;
  logic                in_acc;
  logic                out_valid_q, out_valid_d;
  logic [N_OUT-1:0]    out_data_q, out_data_d;

  logic [N_PROD-1:0]   prod;
  logic [N_OUT-1:0]    sop;
  logic [N_OUT-1:0]    mask;

  // ---------------------------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------------------------

  // A bit presented together with a restart pulse is dropped.
  assign cfg_acc  = cfg_ready & bus.cfg_valid & ~bus.cfg_start;
  assign last_bit = (cnt_q == CntW'(CFG_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_start) state_d = StLoad;
      end
      StLoad: begin
        if (bus.cfg_start) begin
          state_d = StLoad;
        end else if (cfg_acc && last_bit) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    cfg_busy  = 1'b0;
    cfg_done  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
      StCommit: begin
        cfg_busy = 1'b1;
        cfg_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_busy  = cfg_busy;
  assign bus.cfg_done  = cfg_done;

  // ---------------------------------------------------------------------------------------
  // Config banks and bit counter
  // ---------------------------------------------------------------------------------------

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if ((state_q != StCommit) && bus.cfg_start) begin
      // Stale shadow bits from a discarded partial frame are overwritten by the full frame.
      cnt_d = '0;
    end else if (cfg_acc) begin
      shadow_d[cnt_q] = bus.cfg_bit;
      cnt_d           = last_bit ? '0 : cnt_q + CntW'(1);
    end
    if (state_q == StCommit) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // SOP evaluation from the active bank
  // ---------------------------------------------------------------------------------------

  // A literal with both pos and neg set can never be satisfied, so code 11 forces the
  // product to 0 without a dedicated check.
  always_comb begin
    prod = '1;
    for (int p = 0; p < N_PROD; p++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (active_q[p * ProdBits + 2 * i] && !bus.in_data[i]) begin
          prod[p] = 1'b0;
        end
        if (active_q[p * ProdBits + 2 * i + 1] && bus.in_data[i]) begin
          prod[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    sop = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int p = 0; p < N_PROD; p++) begin
        if (prod[p] && active_q[p * ProdBits + 2 * N_IN + j]) begin
          sop[j] = 1'b1;
        end
      end
    end
  end

`ifdef SOP_EVAL_OUT_MASK_EN
  assign mask = active_q[N_PROD * ProdBits +: N_OUT];
`else
  assign mask = '1;
`endif

  // ---------------------------------------------------------------------------------------
  // Single-stage result register
  // ---------------------------------------------------------------------------------------

  // Operands are held off during commit so none straddles the bank swap.
  assign in_ready = (~out_valid_q | bus.out_ready) & (state_q != StCommit);
  assign in_acc   = bus.in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = sop & mask;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_sop_shared_cfg_eval.sv
`timescale 1ns/1ps
module tb_sop_shared_cfg_eval;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned N_PROD = 6;
  localparam int unsigned PB     = 2 * N_IN + N_OUT;
`ifdef SOP_EVAL_OUT_MASK_EN
  localparam int unsigned CFG_BITS = N_PROD * PB + N_OUT;
`else
  localparam int unsigned CFG_BITS = N_PROD * PB;
`endif

  typedef logic [CFG_BITS-1:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sop_shared_cfg_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  sop_shared_cfg_eval #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .N_PROD(N_PROD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  frame_t           ref_active;
  bit               fbits[$];
  logic [N_OUT-1:0] exp_q[$];
  bit               loading;
  bit               commit_pend;
  logic [N_OUT-1:0] last_drain;
  bit               drained;

  // Spec-level evaluation: decode each literal code and combine the products.
  function automatic logic [N_OUT-1:0] ref_eval(input frame_t f, input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int p = 0; p < N_PROD; p++) begin
      bit term;
      term = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        logic [1:0] code;
        code = {f[p*PB+2*i], f[p*PB+2*i+1]};
        case (code)
          2'b10:   term = term & x[i];
          2'b01:   term = term & ~x[i];
          2'b11:   term = 1'b0;
          default: ;
        endcase
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (f[p*PB+2*N_IN+j] && term) r[j] = 1'b1;
      end
    end
`ifdef SOP_EVAL_OUT_MASK_EN
    for (int j = 0; j < N_OUT; j++) begin
      if (!f[N_PROD*PB+j]) r[j] = 1'b0;
    end
`endif
    return r;
  endfunction

  // codes[2i+1:2i] = {pos,neg} for input i
  function automatic frame_t put_prod(input frame_t f, input int p,
                                      input logic [2*N_IN-1:0] codes,
                                      input logic [N_OUT-1:0] act);
    frame_t r;
    r = f;
    for (int i = 0; i < N_IN; i++) begin
      r[p*PB+2*i]   = codes[2*i+1];
      r[p*PB+2*i+1] = codes[2*i];
    end
    for (int j = 0; j < N_OUT; j++) r[p*PB+2*N_IN+j] = act[j];
    return r;
  endfunction

`ifdef SOP_EVAL_OUT_MASK_EN
  function automatic frame_t put_mask(input frame_t f, input logic [N_OUT-1:0] m);
    frame_t r;
    r = f;
    for (int j = 0; j < N_OUT; j++) r[N_PROD*PB+j] = m[j];
    return r;
  endfunction
`endif

  // p0=in0&in2&in3, p1=in2&in3, p2=in2, p3=in0, p4=~in0, p5=1; p4->out0, p0..p3->out1
  function automatic frame_t base_frame();
    frame_t f;
    f = '0;
    f = put_prod(f, 0, 8'b10_10_00_10, 2'b10);
    f = put_prod(f, 1, 8'b10_10_00_00, 2'b10);
    f = put_prod(f, 2, 8'b00_10_00_00, 2'b10);
    f = put_prod(f, 3, 8'b00_00_00_10, 2'b10);
    f = put_prod(f, 4, 8'b00_00_00_01, 2'b01);
    f = put_prod(f, 5, 8'b00_00_00_00, 2'b00);
`ifdef SOP_EVAL_OUT_MASK_EN
    f = put_mask(f, 2'b11);
`endif
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f = '0;
    for (int p = 0; p < N_PROD; p++) begin
      logic [2*N_IN-1:0] c;
      for (int i = 0; i < N_IN; i++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        c[2*i+:2] = (r < 5) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11;
      end
      f = put_prod(f, p, c, N_OUT'($urandom));
    end
`ifdef SOP_EVAL_OUT_MASK_EN
    f = put_mask(f, N_OUT'($urandom));
`endif
    return f;
  endfunction

  function automatic void model_reset();
    ref_active  = '0;
    fbits.delete();
    exp_q.delete();
    loading     = 1'b0;
    commit_pend = 1'b0;
  endfunction

  // Called at the falling edge: compare outputs, then advance the model by one cycle.
  task automatic monitor();
    bit exp_ready;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
    exp_ready = (exp_q.size() == 0 || bus.out_ready) && !commit_pend;
    check("in_ready", bus.in_ready, exp_ready);
    check("cfg_ready", bus.cfg_ready, loading);
    check("cfg_busy", bus.cfg_busy, loading || commit_pend);
    check("cfg_done", bus.cfg_done, commit_pend);

    drained = 1'b0;
    if (exp_q.size() != 0 && bus.out_ready) begin
      last_drain = bus.out_data;
      drained    = 1'b1;
      void'(exp_q.pop_front());
    end
    if (bus.in_valid && exp_ready) exp_q.push_back(ref_eval(ref_active, bus.in_data));

    if (commit_pend) begin
      for (int k = 0; k < CFG_BITS; k++) ref_active[k] = fbits[k];
      fbits.delete();
      commit_pend = 1'b0;
    end else if (loading) begin
      if (bus.cfg_start) begin
        fbits.delete();
      end else if (bus.cfg_valid) begin
        fbits.push_back(bus.cfg_bit);
        if (fbits.size() == CFG_BITS) begin
          loading     = 1'b0;
          commit_pend = 1'b1;
        end
      end
    end else if (bus.cfg_start) begin
      loading = 1'b1;
      fbits.delete();
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic();
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.in_data   = N_IN'($urandom);
    bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle_io();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
  endtask

  // restart_at >= 0: send that many junk bits, pulse cfg_start (with a junk bit), then f.
  task automatic load_frame(input frame_t f, input int restart_at, input bit traffic);
    int  k;
    int  guard;
    bit  junk;
    junk  = (restart_at >= 0);
    guard = 0;
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b0;
    step();
    bus.cfg_start = 1'b0;
    k = 0;
    while (k < CFG_BITS) begin
      guard++;
      if (guard > 2000) begin
        check("load_guard", 0, 1);
        break;
      end
      if (traffic) rand_traffic();
      if (junk && k == restart_at) begin
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = 1'($urandom);
        step();
        bus.cfg_start = 1'b0;
        junk = 1'b0;
        k = 0;
        continue;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.cfg_valid = 1'b0;
        step();
        continue;
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = junk ? 1'($urandom) : f[k];
      step();
      k++;
    end
    // Commit cycle: operand offered and a stray cfg_start, both must be refused.
    bus.cfg_valid = 1'b0;
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = N_IN'($urandom);
    bus.out_ready = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    step();
  endtask

  task automatic eval_one(input string tag, input logic [N_IN-1:0] x,
                          input logic [N_OUT-1:0] exp);
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check({tag, "_drained"}, drained, 1);
    check(tag, last_drain, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    logic [N_OUT-1:0] held;

    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_reset();
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_cfg_busy", bus.cfg_busy, 0);
    check("rst_cfg_done", bus.cfg_done, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Zeroed active bank evaluates every output to 0.
    eval_one("rst_eval_f", 4'hF, 2'b00);

    // Directed load and evaluate
    load_frame(base_frame(), -1, 1'b0);
    eval_one("base_0100", 4'b0100, 2'b11);
    eval_one("base_0001", 4'b0001, 2'b10);
    eval_one("base_0000", 4'b0000, 2'b01);
    eval_one("base_1001", 4'b1001, 2'b10);

    // Force-zero code on p4
    load_frame(put_prod(base_frame(), 4, 8'b00_00_00_11, 2'b01), -1, 1'b1);
    idle_io();
    eval_one("fz_0000", 4'b0000, 2'b00);

    // Restart after 30 junk bits, old config live meanwhile
    load_frame(base_frame(), 30, 1'b1);
    idle_io();
    eval_one("rs_0000", 4'b0000, 2'b01);
    eval_one("rs_0100", 4'b0100, 2'b11);

    // Backpressure: hold out_ready low with a steady operand stream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0001;
    step();
    held = exp_q.size() != 0 ? exp_q[0] : '0;
    for (int c = 0; c < 5; c++) begin
      bus.in_data = N_IN'($urandom);
      step();
      check("bp_hold", bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    check("bp_drain", last_drain, 2'b10);
    step();

`ifdef SOP_EVAL_OUT_MASK_EN
    load_frame(put_mask(base_frame(), 2'b10), -1, 1'b0);
    eval_one("mask_0000", 4'b0000, 2'b00);
    eval_one("mask_0100", 4'b0100, 2'b10);
`endif

    // Reset mid-load drops the partial frame and zeroes the active bank
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'($urandom);
      step();
    end
    bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    eval_one("rstmid_0100", 4'b0100, 2'b00);

    // Randomized frames with concurrent operand traffic
    for (int r = 0; r < 6; r++) begin
      f = rand_frame();
      load_frame(f, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, CFG_BITS - 2)) : -1,
                 1'b1);
      for (int c = 0; c < 40; c++) begin
        rand_traffic();
        step();
      end
      idle_io();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
